// File: rtl/rom_loader_pkg.sv
// ============================================================================
// Module : rom_loader_pkg
// Brief  : Shared state encoding, frame field widths and defaults for rom_loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rom_loader_pkg;

    localparam int         c_BYTE_W    = 8;
    localparam int         c_WORD_W    = 16;
    localparam int         c_LEN_W     = 16;
    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_HI  = 3'd1,
        S_LEN_LO  = 3'd2,
        S_DATA_HI = 3'd3,
        S_DATA_LO = 3'd4,
        S_CSUM    = 3'd5,
        S_DONE    = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    // States in which a frame is in flight: bytes are consumed and the timeout runs.
    function automatic logic is_active(input state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
               (s == S_DATA_LO) || (s == S_CSUM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rom_loader_timeout.sv
// ============================================================================
// Module : rom_loader_timeout
// Brief  : Inter-byte idle counter; flags expiry after TIMEOUT_CYCLES idle cycles.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rom_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_en || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != c_LAST) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Fires during the TIMEOUT_CYCLES-th consecutive idle cycle.
    assign o_expired = i_en && !i_clr && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/rom_loader.sv
// ============================================================================
// Module : rom_loader
// Brief  : Frames UART bytes into 16-bit words, writes the instruction ROM and
//          holds the CPU until a complete image is loaded.
//          Optional trailing XOR checksum byte: define ROM_LOADER_CHECKSUM_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int         ADDR_W         = 11,
    parameter logic [7:0] SYNC_BYTE      = c_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_wr_en,
    output logic [ADDR_W-1:0]   o_wr_addr,
    output logic [15:0]         o_wr_data,
    output logic                o_cpu_hold,
    output logic                o_load_done,
    output logic                o_load_err,
    output logic [ADDR_W:0]     o_word_count
);

    localparam logic [c_LEN_W:0] c_DEPTH = (c_LEN_W + 1)'(2 ** ADDR_W);

    state_t                 r_state;
    state_t                 w_state_nxt;
    state_t                 w_after_data;
    logic [7:0]             r_len_hi;
    logic [c_LEN_W-1:0]     r_len;
    logic [7:0]             r_data_hi;
    logic                   r_wr_en;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [15:0]            r_wr_data;
    logic [ADDR_W:0]        r_word_count;
    logic                   w_expired;
    logic                   w_active;
    logic                   w_accept;
    logic                   w_restart;
    logic [c_LEN_W-1:0]     w_len_rx;
    logic [c_LEN_W:0]       w_cnt_p1;
    logic                   w_last_word;

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]             r_csum;
`endif

    assign w_active  = is_active(r_state);
    assign w_accept  = i_rx_valid && w_active;
    assign w_restart = i_rx_valid && (i_rx_data == SYNC_BYTE) &&
                       ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    assign w_len_rx  = {r_len_hi, i_rx_data};
    // No write can be pending when a low byte arrives, so the count is current here.
    assign w_cnt_p1    = (c_LEN_W + 1)'(r_word_count) + (c_LEN_W + 1)'(1);
    assign w_last_word = (w_cnt_p1 == {1'b0, r_len});

`ifdef ROM_LOADER_CHECKSUM_EN
    assign w_after_data = S_CSUM;
`else
    assign w_after_data = S_DONE;
`endif

    rom_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (w_active),
        .i_clr     (i_rx_valid),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_restart) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (i_rx_valid) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (i_rx_valid) begin
                    if ({1'b0, w_len_rx} > c_DEPTH)  w_state_nxt = S_ERROR;
                    else if (w_len_rx == '0)         w_state_nxt = w_after_data;
                    else                             w_state_nxt = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (i_rx_valid) w_state_nxt = S_DATA_LO;
            end
            S_DATA_LO: begin
                if (i_rx_valid) w_state_nxt = w_last_word ? w_after_data : S_DATA_HI;
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (i_rx_valid) w_state_nxt = (i_rx_data == r_csum) ? S_DONE : S_ERROR;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_expired) w_state_nxt = S_ERROR;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_len_hi     <= '0;
            r_len        <= '0;
            r_data_hi    <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_word_count <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_wr_en) begin
                r_wr_addr    <= r_wr_addr + ADDR_W'(1);
                r_word_count <= r_word_count + (ADDR_W + 1)'(1);
            end
            // A restart landing on the final write cycle takes priority over the increment.
            if (w_restart) begin
                r_wr_addr    <= '0;
                r_word_count <= '0;
            end
            if (w_accept) begin
                case (r_state)
                    S_LEN_HI:  r_len_hi  <= i_rx_data;
                    S_LEN_LO:  r_len     <= w_len_rx;
                    S_DATA_HI: r_data_hi <= i_rx_data;
                    S_DATA_LO: begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= {r_data_hi, i_rx_data};
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_csum <= '0;
        end else if (w_restart) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= r_csum ^ i_rx_data;
        end
    end
`endif

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_cpu_hold   = (r_state != S_DONE);
    assign o_load_done  = (r_state == S_DONE);
    assign o_load_err   = (r_state == S_ERROR);
    assign o_word_count = r_word_count;

endmodule

`default_nettype wire

// File: tb/tb_rom_loader.sv
// ============================================================================
// Module : tb_rom_loader
// Brief  : Randomized self-checking bench for rom_loader against a frame-level
//          reference model (expected write list and final status per frame).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rom_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int TMO    = 40;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    int n_chk  = 0;
    int n_pass = 0;

    logic [ADDR_W-1:0] obs_addr[$];
    logic [15:0]       obs_data[$];
    logic [15:0]       fw[$];

    always #5 clk = ~clk;

    rom_loader #(
        .ADDR_W         (ADDR_W),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_cpu_hold   (cpu_hold),
        .o_load_done  (load_done),
        .o_load_err   (load_err),
        .o_word_count (word_count)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one byte for one cycle; returns one cycle after acceptance, plus gap cycles.
    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        idle(gap);
    endtask

    function automatic logic [7:0] rnd_byte();
        return ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ":wr_en"},   32'(wr_en),      32'd0);
        check_val({tag, ":wr_addr"}, 32'(wr_addr),    32'd0);
        check_val({tag, ":wr_data"}, 32'(wr_data),    32'd0);
        check_val({tag, ":hold"},    32'(cpu_hold),   32'd1);
        check_val({tag, ":done"},    32'(load_done),  32'd0);
        check_val({tag, ":err"},     32'(load_err),   32'd0);
        check_val({tag, ":count"},   32'(word_count), 32'd0);
    endtask

    // Sends a complete frame built from fw[0..len-1] and checks it against the frame model.
    task automatic run_frame(input int len, input bit bad_csum, input int maxgap, input string tag);
        logic [7:0]  cs;
        logic [7:0]  junk;
        logic [15:0] l;
        bit          ok;
        int          nw;
        obs_addr.delete();
        obs_data.delete();
        repeat ($urandom_range(0, 2)) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == 8'hA5) junk = 8'h5A;
            send(junk, $urandom_range(0, maxgap));
        end
        l  = 16'(len);
        cs = l[15:8] ^ l[7:0];
        send(8'hA5, $urandom_range(0, maxgap));
        send(l[15:8], $urandom_range(0, maxgap));
        send(l[7:0], $urandom_range(0, maxgap));
        ok = (len <= DEPTH);
        nw = ok ? len : 0;
        if (ok) begin
            for (int i = 0; i < len; i++) begin
                send(fw[i][15:8], $urandom_range(0, maxgap));
                send(fw[i][7:0], $urandom_range(0, maxgap));
                cs = cs ^ fw[i][15:8] ^ fw[i][7:0];
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            send(bad_csum ? (cs ^ 8'h01) : cs, 0);
            if (bad_csum) ok = 1'b0;
`endif
        end
        idle(3);
        check_val({tag, ":writes"}, 32'(obs_addr.size()), 32'(nw));
        for (int i = 0; i < nw && i < obs_addr.size(); i++) begin
            check_val({tag, ":addr"}, 32'(obs_addr[i]), 32'(i % DEPTH));
            check_val({tag, ":data"}, 32'(obs_data[i]), 32'(fw[i]));
        end
        check_val({tag, ":done"},    32'(load_done),  32'(ok));
        check_val({tag, ":err"},     32'(load_err),   32'(!ok));
        check_val({tag, ":hold"},    32'(cpu_hold),   32'(!ok));
        check_val({tag, ":count"},   32'(word_count), 32'(nw));
        check_val({tag, ":wr_addr"}, 32'(wr_addr),    32'(nw % DEPTH));
    endtask

    initial begin
        int len;
        bit bad;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Two-word image, back-to-back strobes.
        fw = '{16'h1234, 16'hABCD};
        run_frame(2, 1'b0, 0, "t1");

        // Write latency: low byte accepted in cycle N gives a single WR_EN pulse in N+1.
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'hBE, 0);
        send(8'hEF, 0);
        check_val("lat:wr_en",   32'(wr_en),   32'd1);
        check_val("lat:wr_data", 32'(wr_data), 32'hBEEF);
        check_val("lat:wr_addr", 32'(wr_addr), 32'd0);
        idle(1);
        check_val("lat:pulse",   32'(wr_en),   32'd0);
`ifdef ROM_LOADER_CHECKSUM_EN
        send(8'h00 ^ 8'h01 ^ 8'hBE ^ 8'hEF, 0);
`endif
        idle(2);
        check_val("lat:done",    32'(load_done), 32'd1);

        run_frame(0, 1'b0, 1, "t2_len0");
        run_frame(DEPTH + 1, 1'b0, 1, "t3_toolong");

        fw.delete();
        for (int i = 0; i < DEPTH; i++) fw.push_back({rnd_byte(), rnd_byte()});
        run_frame(DEPTH, 1'b0, 1, "full");

        // Inter-byte timeout after one written word, then recovery.
        obs_addr.delete();
        obs_data.delete();
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h03, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        idle(TMO - 5);
        check_val("tmo:early_err", 32'(load_err), 32'd0);
        check_val("tmo:early_hold", 32'(cpu_hold), 32'd1);
        idle(10);
        check_val("tmo:err",    32'(load_err),        32'd1);
        check_val("tmo:done",   32'(load_done),       32'd0);
        check_val("tmo:hold",   32'(cpu_hold),        32'd1);
        check_val("tmo:writes", 32'(obs_data.size()), 32'd1);
        check_val("tmo:count",  32'(word_count),      32'd1);
        fw = '{16'h0000};
        run_frame(1, 1'b0, 0, "t4_recover");

`ifdef ROM_LOADER_CHECKSUM_EN
        fw = '{16'h1234, 16'hABCD};
        run_frame(2, 1'b1, 0, "t5_badcsum");
`endif

        for (int it = 0; it < 20; it++) begin
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(DEPTH - 1, DEPTH + 2)
                                              : $urandom_range(0, DEPTH);
            bad = 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            bad = ($urandom_range(0, 3) == 0);
`endif
            fw.delete();
            for (int i = 0; i < len; i++) fw.push_back({rnd_byte(), rnd_byte()});
            run_frame(len, bad, $urandom_range(0, 4), "rand");
        end

        // Asynchronous reset while waiting for a DATA_LO byte.
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h02, 0);
        send(8'h12, 1);
        send(8'h34, 1);
        send(8'h56, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        idle(2);
        rst = 1'b0;
        idle(1);
        check_reset_outputs("t6_after");
        fw = '{16'hC0DE};
        run_frame(1, 1'b0, 1, "t6_recover");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
